uart_tx_param: RTL

Parametrised UART transmitter with an input FIFO, runtime-selectable parity and stop-bit count, and configurable data width and oversampling ratio. It sits between the system-side byte producer (ALU result path, command interface) and the serial pin, and is driven by the shared baud tick generator. It replaces the fixed 8N1, single-word, unbuffered transmitter. The line now idles high, as the standard requires.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_tx_fifo.sv | 53 +++++
 rtl/uart_tx_param.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmitter slice:
//   - one-hot state encoding and the FSM state type
//   - parity mode codes
//   - parity_bit(): parity of a payload for a given mode
package uart_pkg;

    localparam logic [5:0] ST_IDLE   = 6'b000001;
    localparam logic [5:0] ST_START  = 6'b000010;
    localparam logic [5:0] ST_DATA   = 6'b000100;
    localparam logic [5:0] ST_PARITY = 6'b001000;
    localparam logic [5:0] ST_STOP   = 6'b010000;
    localparam logic [5:0] ST_DONE   = 6'b100000;

    typedef enum logic [5:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP,
        S_DONE   = ST_DONE
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Payload is zero-extended to 9 bits; the extra zeros do not change the XOR.
    // Mode 2'b11 falls into the default and behaves as no parity.
    function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
        case (mode)
            PAR_NONE: return 1'b0;
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~(^data);
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Synchronous FIFO buffering words for the UART transmitter.
// Ports:
//   i_clock, i_reset_n : clock, async active-low reset (empties the FIFO)
//   push, din          : write request and data (ignored when full)
//   pop                : remove head word (ignored when empty)
//   dout               : head-of-queue, combinational
//   full, empty        : status from the registered pointers
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 full,
    output logic                 empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 wr_en;
    logic                 rd_en;

    // Pointers carry one extra wrap bit: equal low bits with differing wrap
    // bits means full, fully equal means empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param
// Parametrised UART transmitter with input FIFO, runtime parity and stop-bit
// selection. Line idles high.
//
// state  | meaning
// IDLE   | line high; pops the head word when the FIFO is not empty
// START  | start bit (low) for OVERSAMPLE ticks
// DATA   | DATA_BITS payload bits, LSB first
// PARITY | optional parity bit
// STOP   | one or two stop bits (high)
// DONE   | one-cycle o_done pulse, then back to IDLE
//
// Ports:
//   i_clock, i_reset_n         : clock, async active-low reset
//   i_tick                     : baud oversample strobe
//   i_data, i_valid, o_ready   : FIFO push interface
//   i_parity_mode, i_two_stop  : frame format, latched at frame start
//   o_tx                       : registered serial output
//   o_busy, o_done, o_overflow : status
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_tick,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    input  logic [1:0]           i_parity_mode,
    input  logic                 i_two_stop,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overflow
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    uart_state_t          state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 par_en_q, par_en_d;
    logic                 par_val_q, par_val_d;
    logic                 two_stop_q, two_stop_d;
    logic                 stop2_q, stop2_d;

    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [8:0]           dout_ext;
    logic                 tick_end;

    // o_ready comes from the pre-pop count, so a push into a full FIFO is
    // refused even if the FSM pops in the same cycle.
    assign o_ready    = ~fifo_full;
    assign o_overflow = i_valid & fifo_full;
    assign fifo_push  = i_valid & ~fifo_full;
    assign fifo_pop   = (state_q == S_IDLE) & ~fifo_empty;
    assign tick_end   = i_tick & (tick_q == TICK_LAST);

    always_comb begin
        dout_ext = '0;
        dout_ext[DATA_BITS-1:0] = fifo_dout;
    end

    uart_tx_fifo #(
        .DATA_BITS (DATA_BITS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .din      (i_data),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        par_en_d   = par_en_q;
        par_val_d  = par_val_q;
        two_stop_d = two_stop_q;
        stop2_d    = stop2_q;

        // Ticks only advance the bit timer inside a frame.
        if (i_tick && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            tick_d = tick_end ? '0 : tick_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    shift_d    = fifo_dout;
                    par_en_d   = (i_parity_mode == PAR_EVEN) || (i_parity_mode == PAR_ODD);
                    par_val_d  = parity_bit(dout_ext, i_parity_mode);
                    two_stop_d = i_two_stop;
                    stop2_d    = 1'b0;
                    tick_d     = '0;
                    bit_d      = '0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (tick_end) begin
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        if (par_en_q) begin
                            tx_d    = par_val_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (tick_end) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick_end) begin
                    if (two_stop_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            par_en_q   <= 1'b0;
            par_val_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            par_en_q   <= par_en_d;
            par_val_q  <= par_val_d;
            two_stop_q <= two_stop_d;
            stop2_q    <= stop2_d;
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule
